// File: rtl/disassembler_pkg.sv
// Shared constants, state encoding and header field offsets for the ingress disassembler.
package disassembler_pkg;

  localparam int PHIT_SIZE    = 512;
  localparam int SIMD_DEGREE  = 16;
  localparam int LANE_W       = 32;
  localparam int HEADER_BYTES = 48;
  localparam int HEADER_W     = HEADER_BYTES * 8;
  localparam int HEADER_DEG   = HEADER_BYTES / 4;
  localparam int RES_DEG      = SIMD_DEGREE - HEADER_DEG;
  localparam int RES_W        = RES_DEG * LANE_W;

  // SPL field and the IPv4 checksum window (ten 16-bit words from bit 112 up)
  localparam int SPL_LSB      = 128;
  localparam int SPL_W        = 16;
  localparam int CSUM_LSB     = 112;
  localparam int CSUM_WORDS   = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

endpackage

// File: rtl/disassembler_hdr_csum_check.sv
// Combinational IPv4 header check: one's-complement sum of ten 16-bit words must fold to 16'hFFFF.
module hdr_csum_check
  import disassembler_pkg::*;
(
  input  logic [HEADER_W-1:0] i_header,
  output logic                o_ok
);

  logic [15:0] w_word [CSUM_WORDS];
  logic [19:0] w_sum;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;

  genvar gi;
  generate
    for (gi = 0; gi < CSUM_WORDS; gi++) begin : g_word
      assign w_word[gi] = i_header[CSUM_LSB + 16*gi +: 16];
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < CSUM_WORDS; k++) begin
      w_sum = w_sum + 20'(w_word[k]);
    end
  end

  // Two folds are enough: the first leaves at most a single carry bit.
  assign w_fold1 = 17'(w_sum[15:0]) + 17'(w_sum[19:16]);
  assign w_fold2 = w_fold1[15:0] + 16'(w_fold1[16]);
  assign o_ok    = (w_fold2 == 16'hFFFF);

endmodule

// File: rtl/reg_enr.sv
// Generic enabled register with asynchronous active-high reset.
module reg_enr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/disassembler.sv
// Ingress disassembler: strips the header beat and shifts payload down by HEADER_DEG lanes.
module disassembler
  import disassembler_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PHIT_SIZE-1:0]   tdata_in,
  input  logic [SIMD_DEGREE-1:0] tvalid_in,
  input  logic [SIMD_DEGREE-1:0] tlast_in,
  output logic                   in_ready,
  output logic [PHIT_SIZE-1:0]   tdata_out,
  output logic [SIMD_DEGREE-1:0] tvalid_out,
  output logic [SIMD_DEGREE-1:0] tlast_out,
  input  logic                   out_ready,
  output logic [HEADER_W-1:0]    header_out,
  output logic                   header_valid,
  output logic [SPL_W-1:0]       spl_out,
  output logic                   checksum_ok
);

  state_t                   r_state;
  logic [RES_W-1:0]         r_res_data;
  logic [RES_DEG-1:0]       r_res_valid;
  logic [PHIT_SIZE-1:0]     r_tdata;
  logic [SIMD_DEGREE-1:0]   r_tvalid;
  logic [SIMD_DEGREE-1:0]   r_tlast;
  logic                     r_header_valid;
  logic                     r_checksum_ok;

  logic                     w_slot_free;
  logic                     w_accept;
  logic                     w_last;
  logic                     w_hdr_en;
  logic                     w_csum_ok;
  logic [RES_W-1:0]         w_in_res_data;
  logic [RES_DEG-1:0]       w_in_res_valid;

  assign w_slot_free    = out_ready || !(|r_tvalid);
  assign in_ready       = w_slot_free && (r_state != FLUSH);
  assign w_accept       = (|tvalid_in) && in_ready;
  assign w_last         = |tlast_in;
  assign w_hdr_en       = w_accept && (r_state == IDLE);
  assign w_in_res_data  = tdata_in[PHIT_SIZE-1 -: RES_W];
  assign w_in_res_valid = tvalid_in[SIMD_DEGREE-1 -: RES_DEG];

  reg_enr #(.W(HEADER_W)) u_hdr_reg (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_hdr_en),
    .i_d  (tdata_in[HEADER_W-1:0]),
    .o_q  (header_out)
  );

  hdr_csum_check u_csum (
    .i_header (tdata_in[HEADER_W-1:0]),
    .o_ok     (w_csum_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_res_data     <= '0;
      r_res_valid    <= '0;
      r_tdata        <= '0;
      r_tvalid       <= '0;
      r_tlast        <= '0;
      r_header_valid <= 1'b0;
      r_checksum_ok  <= 1'b0;
    end else begin
      r_header_valid <= 1'b0;
      // A consumed beat retires unless a new one is loaded below.
      if (out_ready) begin
        r_tvalid <= '0;
        r_tlast  <= '0;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_checksum_ok  <= w_csum_ok;
            r_header_valid <= 1'b1;
            r_res_data     <= w_in_res_data;
            r_res_valid    <= w_in_res_valid;
            if (!w_last)                r_state <= STREAM;
            else if (|w_in_res_valid)   r_state <= FLUSH;
            else                        r_state <= IDLE;
          end
        end
        STREAM: begin
          if (w_accept) begin
            r_tdata     <= {tdata_in[HEADER_W-1:0], r_res_data};
            r_tvalid    <= {tvalid_in[HEADER_DEG-1:0], r_res_valid};
            r_res_data  <= w_in_res_data;
            r_res_valid <= w_in_res_valid;
            if (w_last && (|w_in_res_valid)) begin
              r_tlast <= '0;
              r_state <= FLUSH;
            end else if (w_last) begin
              r_tlast <= '1;
              r_state <= IDLE;
            end else begin
              r_tlast <= '0;
            end
          end
        end
        FLUSH: begin
          if (w_slot_free) begin
            r_tdata     <= PHIT_SIZE'(r_res_data);
            r_tvalid    <= SIMD_DEGREE'(r_res_valid);
            r_tlast     <= '1;
            r_res_data  <= '0;
            r_res_valid <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tdata_out    = r_tdata;
  assign tvalid_out   = r_tvalid;
  assign tlast_out    = r_tlast;
  assign header_valid = r_header_valid;
  assign checksum_ok  = r_checksum_ok;
  assign spl_out      = header_out[SPL_LSB +: SPL_W];

endmodule

// File: tb/tb_disassembler.sv
// Directed self-checking bench for the disassembler: realignment, flush, stall, checksum and reset.
module tb_disassembler;

  logic         clk;
  logic         rst;
  logic [511:0] tdata_in;
  logic [15:0]  tvalid_in;
  logic [15:0]  tlast_in;
  logic         in_ready;
  logic [511:0] tdata_out;
  logic [15:0]  tvalid_out;
  logic [15:0]  tlast_out;
  logic         out_ready;
  logic [383:0] header_out;
  logic         header_valid;
  logic [15:0]  spl_out;
  logic         checksum_ok;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [511:0] d;
    logic [15:0]  v;
    logic [15:0]  l;
  } beat_t;
  beat_t q[$];

  disassembler dut (
    .clk          (clk),
    .rst          (rst),
    .tdata_in     (tdata_in),
    .tvalid_in    (tvalid_in),
    .tlast_in     (tlast_in),
    .in_ready     (in_ready),
    .tdata_out    (tdata_out),
    .tvalid_out   (tvalid_out),
    .tlast_out    (tlast_out),
    .out_ready    (out_ready),
    .header_out   (header_out),
    .header_valid (header_valid),
    .spl_out      (spl_out),
    .checksum_ok  (checksum_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] mk_beat(input int base);
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[32*j +: 32] = 32'(base + j);
    return r;
  endfunction

  function automatic logic [511:0] mk_out(input int rbase, input int ibase);
    logic [511:0] r;
    for (int j = 0; j < 16; j++)
      r[32*j +: 32] = (j < 4) ? 32'(rbase + j) : 32'(ibase + j - 4);
    return r;
  endfunction

  function automatic logic [511:0] mk_flush(input int rbase);
    logic [511:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[32*j +: 32] = 32'(rbase + j);
    return r;
  endfunction

  function automatic logic [511:0] hdr_of(input logic [511:0] b);
    logic [511:0] r;
    r = '0;
    r[383:0] = b[383:0];
    return r;
  endfunction

  // Present a beat at a negedge, hold it until accepted, return at the following negedge.
  task automatic send(input logic [511:0] d, input logic [15:0] v, input logic [15:0] l);
    int t;
    tdata_in  = d;
    tvalid_in = v;
    tlast_in  = l;
    #1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    tvalid_in = '0;
    tlast_in  = '0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (|tvalid_out && out_ready) q.push_back('{d: tdata_out, v: tvalid_out, l: tlast_out});
    end
  end

  task automatic run4(input bit stall);
    logic [511:0] e_d;
    logic [15:0]  e_v;
    logic [15:0]  e_l;
    q.delete();
    fork
      begin
        for (int k = 0; k < 4; k++) send(mk_beat(16*k), 16'hFFFF, (k == 3) ? 16'hFFFF : 16'h0000);
      end
      begin
        if (stall) begin
          repeat (2) @(negedge clk);
          out_ready = 1'b0;
          for (int c = 0; c < 3; c++) begin
            #2;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_tvalid", tvalid_out, 16'hFFFF);
            chk("stall_tdata", tdata_out, mk_out(12, 16));
            @(negedge clk);
          end
          out_ready = 1'b1;
        end
      end
    join
    repeat (3) @(negedge clk);
    chk(stall ? "stall_nbeats" : "run_nbeats", q.size(), 4);
    for (int k = 0; k < 4 && k < q.size(); k++) begin
      if (k < 3) begin
        e_d = mk_out(16*k + 12, 16*(k+1));
        e_v = 16'hFFFF;
        e_l = 16'h0000;
      end else begin
        e_d = mk_flush(60);
        e_v = 16'h000F;
        e_l = 16'hFFFF;
      end
      chk($sformatf("%s_beat%0d_data", stall ? "stall" : "run", k), q[k].d, e_d);
      chk($sformatf("%s_beat%0d_valid", stall ? "stall" : "run", k), q[k].v, e_v);
      chk($sformatf("%s_beat%0d_last", stall ? "stall" : "run", k), q[k].l, e_l);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [511:0] ip;
    logic [15:0]  w [10];

    rst       = 1'b1;
    out_ready = 1'b1;
    tdata_in  = '0;
    tvalid_in = '0;
    tlast_in  = '0;
    #2;
    chk("rst_tvalid", tvalid_out, 0);
    chk("rst_tlast", tlast_out, 0);
    chk("rst_header", header_out, 0);
    chk("rst_hvalid", header_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Two-beat packet, full last beat -> one realigned beat plus a flush beat
    send(mk_beat(0), 16'hFFFF, 16'h0000);
    chk("p1_hvalid", header_valid, 1);
    chk("p1_header", header_out, hdr_of(mk_beat(0)));
    chk("p1_spl", spl_out, 16'h0004);
    chk("p1_csum", checksum_ok, 0);
    chk("p1_no_out", tvalid_out, 0);
    send(mk_beat(16), 16'hFFFF, 16'h8000);
    chk("p1_hvalid_pulse", header_valid, 0);
    chk("p1_b1_data", tdata_out, mk_out(12, 16));
    chk("p1_b1_valid", tvalid_out, 16'hFFFF);
    chk("p1_b1_last", tlast_out, 0);
    chk("p1_flush_stall_in", in_ready, 0);
    @(negedge clk);
    chk("p1_fl_data", tdata_out, mk_flush(28));
    chk("p1_fl_valid", tvalid_out, 16'h000F);
    chk("p1_fl_last", tlast_out, 16'hFFFF);
    @(negedge clk);
    chk("p1_idle_valid", tvalid_out, 0);

    // Short last beat: residue empty, so no flush
    send(mk_beat(0), 16'hFFFF, 16'h0000);
    send(mk_beat(16), 16'h00FF, 16'h0080);
    chk("p2_data", tdata_out, mk_out(12, 16));
    chk("p2_valid", tvalid_out, 16'h0FFF);
    chk("p2_last", tlast_out, 16'hFFFF);
    @(negedge clk);
    chk("p2_no_flush", tvalid_out, 0);
    chk("p2_in_ready", in_ready, 1);

    // Header-only packets
    send(mk_beat(0), 16'h0FFF, 16'h0800);
    chk("p3_hvalid", header_valid, 1);
    chk("p3_no_out", tvalid_out, 0);
    @(negedge clk);
    chk("p3_still_none", tvalid_out, 0);
    chk("p3_hvalid_clr", header_valid, 0);
    send(mk_beat(0), 16'hFFFF, 16'hFFFF);
    chk("p4_hvalid", header_valid, 1);
    chk("p4_no_out", tvalid_out, 0);
    @(negedge clk);
    chk("p4_fl_data", tdata_out, mk_flush(12));
    chk("p4_fl_valid", tvalid_out, 16'h000F);
    chk("p4_fl_last", tlast_out, 16'hFFFF);
    @(negedge clk);

    // IPv4 header: sum of other words folds to 16'h595F, checksum word 16'hA6A0
    w = '{16'h4500, 16'h1234, 16'h0000, 16'h4000, 16'h4011,
          16'hA6A0, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7};
    ip = '0;
    for (int k = 0; k < 10; k++) ip[112 + 16*k +: 16] = w[k];
    send(ip, 16'h0FFF, 16'h0001);
    chk("ip_spl", spl_out, 16'h1234);
    chk("ip_csum_ok", checksum_ok, 1);
    ip[200] = ~ip[200];
    send(ip, 16'h0FFF, 16'h0001);
    chk("ip_bad_spl", spl_out, 16'h1234);
    chk("ip_csum_bad", checksum_ok, 0);
    @(negedge clk);

    // Four-beat packet, unstalled then with a 3-cycle downstream stall
    run4(1'b0);
    run4(1'b1);

    // Asynchronous reset in the middle of a packet
    send(mk_beat(0), 16'hFFFF, 16'h0000);
    send(mk_beat(16), 16'hFFFF, 16'h0000);
    chk("pre_rst_valid", tvalid_out, 16'hFFFF);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tvalid", tvalid_out, 0);
    chk("arst_tdata", tdata_out, 0);
    chk("arst_tlast", tlast_out, 0);
    chk("arst_header", header_out, 0);
    chk("arst_spl", spl_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(mk_beat(100), 16'h0FFF, 16'h0800);
    chk("post_rst_hvalid", header_valid, 1);
    chk("post_rst_header", header_out, hdr_of(mk_beat(100)));
    chk("post_rst_no_out", tvalid_out, 0);
    @(negedge clk);
    chk("post_rst_no_leak", tvalid_out, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
